vga_sync_monitor: RTL and testbench

Receive-side counterpart of the VGA timing generator. Samples the vga_h_sync/vga_v_sync pair, recovers pixel coordinates, measures line and frame lengths, and reports lock status and timing errors. Runs on the same pixel clock as the sync generator (DIV_CLK[1]). Serves as an on-chip timing checker and as a coordinate source for downstream capture logic.

---
 rtl/vga_sync_monitor.sv | 217 +++++++++++++++++++++
 tb/tb_vga_sync_monitor.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_monitor.sv
// vga_sync_monitor
//   Receive-side VGA timing checker. Samples an active-low hsync/vsync pair,
//   recovers pixel coordinates, measures line/frame length, tracks lock and
//   flags timing faults.
//
//   Optional build macro: VGA_MONITOR_STATS_EN
//     defined   -> bad_frames counts err_frame pulses and sig_lost rises
//                  (saturating at 255, cleared only by reset)
//     undefined -> bad_frames is tied to 0
//
//   Ports
//     clk          pixel clock
//     reset        asynchronous active-low reset
//     vga_h_sync   horizontal sync, active-low
//     vga_v_sync   vertical sync, active-low
//     rx_x, rx_y   recovered pixel coordinates (0 outside the active area)
//     rx_active    recovered display-area flag
//     locked       timing locked
//     line_len     last measured line length in clocks
//     frame_lines  last measured frame length in lines
//     err_line     1-cycle pulse, line length != H_TOTAL
//     err_frame    1-cycle pulse, bad frame
//     sig_lost     no hsync edge for 2*H_TOTAL clocks
//     bad_frames   bad-frame statistics counter
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   S_SEARCH | no frame reference yet; waiting for the first vsync fall
//   S_TRACK  | counting consecutive good frames toward LOCK_FRAMES
//   S_LOCKED | timing locked; any line or frame error drops back to TRACK
module vga_sync_monitor #(
  parameter int H_TOTAL     = 800,
  parameter int V_TOTAL     = 525,
  parameter int H_BLANK_PRE = 144,
  parameter int V_BLANK_PRE = 35,
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        vga_h_sync,
  input  logic        vga_v_sync,
  output logic [9:0]  rx_x,
  output logic [9:0]  rx_y,
  output logic        rx_active,
  output logic        locked,
  output logic [10:0] line_len,
  output logic [9:0]  frame_lines,
  output logic        err_line,
  output logic        err_frame,
  output logic        sig_lost,
  output logic [7:0]  bad_frames
);

  typedef enum logic [1:0] {
    S_SEARCH = 2'd0,
    S_TRACK  = 2'd1,
    S_LOCKED = 2'd2
  } state_t;

  localparam logic [10:0] H_TOTAL_W = 11'(H_TOTAL);
  localparam logic [10:0] LOST_AT   = 11'(2 * H_TOTAL - 1);
  localparam logic [10:0] H_BEG     = 11'(H_BLANK_PRE);
  localparam logic [10:0] H_END     = 11'(H_BLANK_PRE + H_ACTIVE);
  localparam logic [9:0]  V_TOTAL_W = 10'(V_TOTAL);
  localparam logic [9:0]  V_BEG     = 10'(V_BLANK_PRE);
  localparam logic [9:0]  V_END     = 10'(V_BLANK_PRE + V_ACTIVE);
  localparam logic [3:0]  LOCK_W    = 4'(LOCK_FRAMES);

  state_t      state, state_nxt;
  logic [3:0]  good_cnt, good_cnt_nxt;
  logic        h_q, h_q2, v_q, v_q2;
  logic        h_fall, v_fall;
  logic [10:0] hcnt, hcnt_nxt, line_meas;
  logic [9:0]  vcnt, vcnt_nxt, frame_meas;
  logic        line_valid, line_err_seen;
  logic        err_line_nxt, err_frame_nxt, lost_evt, frame_good;
  logic        locked_nxt, active_nxt;

  assign h_fall = h_q2 & ~h_q;
  assign v_fall = v_q2 & ~v_q;

  always_comb begin
    line_meas    = (hcnt == 11'h7FF) ? hcnt : hcnt + 11'd1;
    err_line_nxt = h_fall & line_valid & (line_meas != H_TOTAL_W);
    // hcnt only passes LOST_AT once per missing-hsync episode
    lost_evt     = ~h_fall & (hcnt == LOST_AT);

    if (h_fall)               hcnt_nxt = '0;
    else if (hcnt == 11'h7FF) hcnt_nxt = hcnt;
    else                      hcnt_nxt = hcnt + 11'd1;

    if (v_fall)                           vcnt_nxt = '0;
    else if (h_fall && vcnt != 10'h3FF)   vcnt_nxt = vcnt + 10'd1;
    else                                  vcnt_nxt = vcnt;

    // an hsync fall coincident with the closing vsync fall belongs to the
    // closing frame, as does a coincident line error
    frame_meas = (h_fall && vcnt != 10'h3FF) ? vcnt + 10'd1 : vcnt;
    frame_good = (frame_meas == V_TOTAL_W) & ~line_err_seen & ~err_line_nxt;
  end

  always_comb begin
    state_nxt     = state;
    good_cnt_nxt  = good_cnt;
    err_frame_nxt = 1'b0;
    if (lost_evt) begin
      state_nxt    = S_SEARCH;
      good_cnt_nxt = '0;
    end else begin
      case (state)
        S_SEARCH: begin
          if (v_fall) begin
            state_nxt    = S_TRACK;
            good_cnt_nxt = '0;
          end
        end
        S_TRACK: begin
          if (v_fall) begin
            if (frame_good) begin
              good_cnt_nxt = good_cnt + 4'd1;
              if (good_cnt + 4'd1 >= LOCK_W) state_nxt = S_LOCKED;
            end else begin
              err_frame_nxt = 1'b1;
              good_cnt_nxt  = '0;
            end
          end
        end
        S_LOCKED: begin
          if (v_fall && !frame_good) begin
            err_frame_nxt = 1'b1;
            state_nxt     = S_TRACK;
            good_cnt_nxt  = '0;
          end else if (err_line_nxt) begin
            state_nxt    = S_TRACK;
            good_cnt_nxt = '0;
          end
        end
        default: begin
          state_nxt    = S_SEARCH;
          good_cnt_nxt = '0;
        end
      endcase
    end
    locked_nxt = (state_nxt == S_LOCKED);
    // coordinates track the counter values being loaded on this edge
    active_nxt = locked_nxt &&
                 (hcnt_nxt >= H_BEG) && (hcnt_nxt < H_END) &&
                 (vcnt_nxt >= V_BEG) && (vcnt_nxt < V_END);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= S_SEARCH;
      good_cnt      <= '0;
      h_q           <= 1'b0;
      h_q2          <= 1'b0;
      v_q           <= 1'b0;
      v_q2          <= 1'b0;
      hcnt          <= '0;
      vcnt          <= '0;
      line_valid    <= 1'b0;
      line_err_seen <= 1'b0;
      line_len      <= '0;
      frame_lines   <= '0;
      err_line      <= 1'b0;
      err_frame     <= 1'b0;
      sig_lost      <= 1'b0;
      locked        <= 1'b0;
      rx_active     <= 1'b0;
      rx_x          <= '0;
      rx_y          <= '0;
    end else begin
      state     <= state_nxt;
      good_cnt  <= good_cnt_nxt;
      h_q       <= vga_h_sync;
      h_q2      <= h_q;
      v_q       <= vga_v_sync;
      v_q2      <= v_q;
      hcnt      <= hcnt_nxt;
      vcnt      <= vcnt_nxt;
      err_line  <= err_line_nxt;
      err_frame <= err_frame_nxt;
      locked    <= locked_nxt;
      rx_active <= active_nxt;
      rx_x      <= active_nxt ? 10'(hcnt_nxt - H_BEG) : 10'd0;
      rx_y      <= active_nxt ? (vcnt_nxt - V_BEG) : 10'd0;

      if (lost_evt)    line_valid <= 1'b0;
      else if (h_fall) line_valid <= 1'b1;

      if (h_fall && line_valid) line_len <= line_meas;

      if (v_fall)            line_err_seen <= 1'b0;
      else if (err_line_nxt) line_err_seen <= 1'b1;

      if (v_fall) frame_lines <= frame_meas;

      if (lost_evt)    sig_lost <= 1'b1;
      else if (h_fall) sig_lost <= 1'b0;
    end
  end

`ifdef VGA_MONITOR_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bad_frames <= '0;
    end else if ((err_frame_nxt || (lost_evt && !sig_lost)) && bad_frames != 8'hFF) begin
      bad_frames <= bad_frames + 8'd1;
    end
  end
`else
  assign bad_frames = '0;
`endif

endmodule

// File: tb/tb_vga_sync_monitor.sv
module tb_vga_sync_monitor;

  localparam int HT   = 40;
  localparam int VT   = 12;
  localparam int HBP  = 8;
  localparam int VBP  = 3;
  localparam int HA   = 24;
  localparam int VA   = 8;
  localparam int LF   = 2;
  localparam int HS_W = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        vga_h_sync = 1'b1;
  logic        vga_v_sync = 1'b1;
  logic [9:0]  rx_x, rx_y;
  logic        rx_active, locked, err_line, err_frame, sig_lost;
  logic [10:0] line_len;
  logic [9:0]  frame_lines;
  logic [7:0]  bad_frames;

  vga_sync_monitor #(
    .H_TOTAL(HT), .V_TOTAL(VT), .H_BLANK_PRE(HBP), .V_BLANK_PRE(VBP),
    .H_ACTIVE(HA), .V_ACTIVE(VA), .LOCK_FRAMES(LF)
  ) dut (
    .clk(clk), .reset(reset), .vga_h_sync(vga_h_sync), .vga_v_sync(vga_v_sync),
    .rx_x(rx_x), .rx_y(rx_y), .rx_active(rx_active), .locked(locked),
    .line_len(line_len), .frame_lines(frame_lines), .err_line(err_line),
    .err_frame(err_frame), .sig_lost(sig_lost), .bad_frames(bad_frames)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int g_frame = 0, g_line = 0, g_cyc = 0;
  int n_el = 0, el_pos = -1, el_len = 0;
  int n_ef = 0, ef_pos = -1;
  int lk_rise = -1, lk_fall = -1, sl_rise = -1, sl_fall = -1;
  int act_cnt = 0, act_first_pos = -1, act_last_pos = -1;
  int act_first_x = 0, act_first_y = 0, act_last_x = 0, act_last_y = 0;
  logic prev_locked = 1'b0, prev_sl = 1'b0;

  function automatic int pos(input int f, input int l, input int c);
    return f * 10000 + l * 100 + c;
  endfunction

  // one clock: wait for the edge, then log events tagged with the stimulus position
  task automatic tick_obs();
    @(posedge clk);
    #1;
    if (err_line === 1'b1) begin
      n_el++; el_pos = pos(g_frame, g_line, g_cyc); el_len = int'(line_len);
    end
    if (err_frame === 1'b1) begin
      n_ef++; ef_pos = pos(g_frame, g_line, g_cyc);
    end
    if (locked === 1'b1 && prev_locked === 1'b0) lk_rise = pos(g_frame, g_line, g_cyc);
    if (locked === 1'b0 && prev_locked === 1'b1) lk_fall = pos(g_frame, g_line, g_cyc);
    if (sig_lost === 1'b1 && prev_sl === 1'b0) sl_rise = pos(g_frame, g_line, g_cyc);
    if (sig_lost === 1'b0 && prev_sl === 1'b1) sl_fall = pos(g_frame, g_line, g_cyc);
    if (rx_active === 1'b1) begin
      if (act_cnt == 0) begin
        act_first_pos = pos(g_frame, g_line, g_cyc);
        act_first_x = int'(rx_x); act_first_y = int'(rx_y);
      end
      act_cnt++;
      act_last_pos = pos(g_frame, g_line, g_cyc);
      act_last_x = int'(rx_x); act_last_y = int'(rx_y);
    end
    prev_locked = locked;
    prev_sl = sig_lost;
  endtask

  task automatic drive(input logic h, input logic v, input int l, input int c);
    vga_h_sync = h;
    vga_v_sync = v;
    g_line = l;
    g_cyc = c;
    tick_obs();
  endtask

  task automatic send_line(input int l, input int len, input int vsw, input logic v0, input logic v1);
    for (int c = 0; c < len; c++)
      drive((c < HS_W) ? 1'b0 : 1'b1, (c < vsw) ? v0 : v1, l, c);
  endtask

  // vsync low for two lines starting at line 0, cycle vphase
  task automatic send_frame(input int stretch, input int vphase, input int nlines);
    int len;
    g_frame++;
    act_cnt = 0;
    for (int l = 0; l < nlines; l++) begin
      len = (l == stretch) ? HT + 1 : HT;
      if (vphase == 0)  send_line(l, len, 0, 1'b1, (l < 2) ? 1'b0 : 1'b1);
      else if (l == 0)  send_line(l, len, vphase, 1'b1, 1'b0);
      else if (l == 1)  send_line(l, len, 0, 1'b0, 1'b0);
      else if (l == 2)  send_line(l, len, vphase, 1'b0, 1'b1);
      else              send_line(l, len, 0, 1'b1, 1'b1);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    vga_h_sync = 1'b1;
    vga_v_sync = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({rx_active, locked, err_line, err_frame, sig_lost} !== 5'b0) begin
      errors++; $display("FAIL reset_flags: got %b expected 00000", {rx_active, locked, err_line, err_frame, sig_lost});
    end
    checks++;
    if (line_len !== 11'd0 || frame_lines !== 10'd0) begin
      errors++; $display("FAIL reset_meas: line_len=%0d frame_lines=%0d expected 0/0", line_len, frame_lines);
    end
    checks++;
    if (rx_x !== 10'd0 || rx_y !== 10'd0 || bad_frames !== 8'd0) begin
      errors++; $display("FAIL reset_coord: rx_x=%0d rx_y=%0d bad_frames=%0d expected 0", rx_x, rx_y, bad_frames);
    end
    reset = 1'b1;
    prev_locked = 1'b0;
    prev_sl = 1'b0;
    repeat (2) drive(1'b1, 1'b1, 0, 0);
  endtask

  task automatic test_nominal_lock();
    int f0, el0, ef0;
    f0 = g_frame; el0 = n_el; ef0 = n_ef; lk_rise = -1;
    repeat (3) send_frame(-1, 0, VT);
    checks++;
    if (lk_rise != pos(f0 + 3, 0, 1)) begin
      errors++; $display("FAIL lock_rise: got pos %0d expected %0d", lk_rise, pos(f0 + 3, 0, 1));
    end
    checks++;
    if (locked !== 1'b1) begin errors++; $display("FAIL locked_nominal: got %0d expected 1", locked); end
    checks++;
    if (line_len !== 11'd40) begin errors++; $display("FAIL line_len_nominal: got %0d expected 40", line_len); end
    checks++;
    if (frame_lines !== 10'd12) begin errors++; $display("FAIL frame_lines_nominal: got %0d expected 12", frame_lines); end
    checks++;
    if (n_el != el0 || n_ef != ef0) begin
      errors++; $display("FAIL nominal_no_err: err_line=%0d err_frame=%0d pulses expected 0/0", n_el - el0, n_ef - ef0);
    end
  endtask

  task automatic test_active_window();
    int f;
    send_frame(-1, 0, VT);
    f = g_frame;
    checks++;
    if (act_cnt != HA * VA) begin errors++; $display("FAIL active_count: got %0d expected %0d", act_cnt, HA * VA); end
    checks++;
    if (act_first_pos != pos(f, 3, 9) || act_first_x != 0 || act_first_y != 0) begin
      errors++; $display("FAIL first_pixel: pos=%0d x=%0d y=%0d expected pos=%0d x=0 y=0", act_first_pos, act_first_x, act_first_y, pos(f, 3, 9));
    end
    checks++;
    if (act_last_pos != pos(f, 10, 32) || act_last_x != 23 || act_last_y != 7) begin
      errors++; $display("FAIL last_pixel: pos=%0d x=%0d y=%0d expected pos=%0d x=23 y=7", act_last_pos, act_last_x, act_last_y, pos(f, 10, 32));
    end
    checks++;
    if (rx_active !== 1'b0 || rx_x !== 10'd0 || rx_y !== 10'd0) begin
      errors++; $display("FAIL blank_coord: active=%0d x=%0d y=%0d expected 0", rx_active, rx_x, rx_y);
    end
  endtask

  task automatic test_line_stretch();
    int f0, el0, ef0;
    f0 = g_frame; el0 = n_el; ef0 = n_ef; lk_rise = -1; lk_fall = -1;
    send_frame(5, 0, VT);
    checks++;
    if (n_el - el0 != 1 || el_pos != pos(f0 + 1, 6, 1) || el_len != 41) begin
      errors++; $display("FAIL stretch_err_line: pulses=%0d pos=%0d len=%0d expected 1 %0d 41", n_el - el0, el_pos, el_len, pos(f0 + 1, 6, 1));
    end
    checks++;
    if (lk_fall != pos(f0 + 1, 6, 1) || locked !== 1'b0) begin
      errors++; $display("FAIL stretch_unlock: pos=%0d locked=%0d expected %0d 0", lk_fall, locked, pos(f0 + 1, 6, 1));
    end
    repeat (3) send_frame(-1, 0, VT);
    checks++;
    if (n_ef - ef0 != 1 || ef_pos != pos(f0 + 2, 0, 1)) begin
      errors++; $display("FAIL stretch_err_frame: pulses=%0d pos=%0d expected 1 %0d", n_ef - ef0, ef_pos, pos(f0 + 2, 0, 1));
    end
    checks++;
    if (lk_rise != pos(f0 + 4, 0, 1)) begin
      errors++; $display("FAIL stretch_relock: got pos %0d expected %0d", lk_rise, pos(f0 + 4, 0, 1));
    end
    checks++;
    if (line_len !== 11'd40) begin errors++; $display("FAIL stretch_line_len: got %0d expected 40", line_len); end
  endtask

  task automatic test_simultaneous();
    int f0, el0, ef0;
    f0 = g_frame; el0 = n_el; ef0 = n_ef; lk_rise = -1; lk_fall = -1;
    send_frame(VT - 1, 0, VT);
    repeat (3) send_frame(-1, 0, VT);
    checks++;
    if (n_el - el0 != 1 || el_pos != pos(f0 + 2, 0, 1)) begin
      errors++; $display("FAIL simul_err_line: pulses=%0d pos=%0d expected 1 %0d", n_el - el0, el_pos, pos(f0 + 2, 0, 1));
    end
    checks++;
    if (n_ef - ef0 != 1 || ef_pos != pos(f0 + 2, 0, 1)) begin
      errors++; $display("FAIL simul_err_frame: pulses=%0d pos=%0d expected 1 %0d", n_ef - ef0, ef_pos, pos(f0 + 2, 0, 1));
    end
    checks++;
    if (lk_fall != pos(f0 + 2, 0, 1) || lk_rise != pos(f0 + 4, 0, 1)) begin
      errors++; $display("FAIL simul_lock: fall=%0d rise=%0d expected %0d %0d", lk_fall, lk_rise, pos(f0 + 2, 0, 1), pos(f0 + 4, 0, 1));
    end
  endtask

  task automatic test_midline_vsync();
    int ef0;
    ef0 = n_ef; lk_fall = -1;
    send_frame(-1, 15, VT);
    checks++;
    if (frame_lines !== 10'd12) begin errors++; $display("FAIL midline_first: got %0d expected 12", frame_lines); end
    send_frame(-1, 15, VT);
    checks++;
    if (frame_lines !== 10'd12) begin errors++; $display("FAIL midline_steady: got %0d expected 12", frame_lines); end
    send_frame(-1, 0, VT);
    checks++;
    if (frame_lines !== 10'd12) begin errors++; $display("FAIL midline_to_coincident: got %0d expected 12", frame_lines); end
    checks++;
    if (n_ef != ef0 || lk_fall != -1 || locked !== 1'b1) begin
      errors++; $display("FAIL midline_lock_kept: err_frame=%0d fall=%0d locked=%0d expected 0 -1 1", n_ef - ef0, lk_fall, locked);
    end
  endtask

  task automatic test_sig_lost();
    int f0, el0;
    f0 = g_frame; lk_fall = -1; sl_rise = -1;
    g_frame++;
    for (int j = 0; j < 60; j++) drive(1'b1, 1'b1, 0, j);
    checks++;
    if (sl_rise != pos(f0 + 1, 0, 41) || sig_lost !== 1'b1) begin
      errors++; $display("FAIL sig_lost_rise: pos=%0d sig_lost=%0d expected %0d 1", sl_rise, sig_lost, pos(f0 + 1, 0, 41));
    end
    checks++;
    if (lk_fall != pos(f0 + 1, 0, 41) || locked !== 1'b0) begin
      errors++; $display("FAIL sig_lost_unlock: pos=%0d locked=%0d expected %0d 0", lk_fall, locked, pos(f0 + 1, 0, 41));
    end
    el0 = n_el; sl_fall = -1; lk_rise = -1;
    repeat (3) send_frame(-1, 0, VT);
    checks++;
    if (sl_fall != pos(f0 + 2, 0, 1)) begin
      errors++; $display("FAIL sig_lost_clear: got pos %0d expected %0d", sl_fall, pos(f0 + 2, 0, 1));
    end
    checks++;
    if (n_el != el0 || line_len !== 11'd40) begin
      errors++; $display("FAIL sig_lost_first_edge: err_line=%0d line_len=%0d expected 0 40", n_el - el0, line_len);
    end
    checks++;
    if (lk_rise != pos(f0 + 4, 0, 1)) begin
      errors++; $display("FAIL sig_lost_relock: got pos %0d expected %0d", lk_rise, pos(f0 + 4, 0, 1));
    end
  endtask

  task automatic test_short_frame();
    int f0, ef0;
    f0 = g_frame; ef0 = n_ef; lk_fall = -1;
    send_frame(-1, 0, VT - 1);
    send_frame(-1, 0, VT);
    checks++;
    if (frame_lines !== 10'd11) begin errors++; $display("FAIL short_frame_lines: got %0d expected 11", frame_lines); end
    checks++;
    if (n_ef - ef0 != 1 || ef_pos != pos(f0 + 2, 0, 1) || lk_fall != pos(f0 + 2, 0, 1)) begin
      errors++; $display("FAIL short_frame_err: pulses=%0d pos=%0d fall=%0d expected 1 %0d", n_ef - ef0, ef_pos, lk_fall, pos(f0 + 2, 0, 1));
    end
    checks++;
`ifdef VGA_MONITOR_STATS_EN
    if (bad_frames !== 8'd4) begin errors++; $display("FAIL bad_frames: got %0d expected 4", bad_frames); end
`else
    if (bad_frames !== 8'd0) begin errors++; $display("FAIL bad_frames: got %0d expected 0", bad_frames); end
`endif
  endtask

  task automatic test_reset_midframe();
    repeat (2) send_frame(-1, 0, VT);
    send_frame(-1, 0, 5);
    send_line(5, 20, 0, 1'b1, 1'b1);
    checks++;
    if (rx_active !== 1'b1 || rx_x !== 10'd10 || rx_y !== 10'd2 || locked !== 1'b1) begin
      errors++; $display("FAIL midframe_coord: active=%0d x=%0d y=%0d locked=%0d expected 1 10 2 1", rx_active, rx_x, rx_y, locked);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({rx_active, locked, err_line, err_frame, sig_lost} !== 5'b0 || rx_x !== 10'd0 || rx_y !== 10'd0) begin
      errors++; $display("FAIL async_reset_flags: flags=%b x=%0d y=%0d expected 0", {rx_active, locked, err_line, err_frame, sig_lost}, rx_x, rx_y);
    end
    checks++;
    if (line_len !== 11'd0 || frame_lines !== 10'd0 || bad_frames !== 8'd0) begin
      errors++; $display("FAIL async_reset_meas: line_len=%0d frame_lines=%0d bad_frames=%0d expected 0", line_len, frame_lines, bad_frames);
    end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_nominal_lock();
    test_active_window();
    test_line_stretch();
    test_simultaneous();
    test_midline_vsync();
    test_sig_lost();
    test_short_frame();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
